// File: rtl/fmc_slave_ctrl.sv
// fmc_slave_ctrl: FMC async SRAM-mode slave bridging host strobes to a valid/ready register bus
module fmc_slave_ctrl #(
    parameter int DataWidth  = 16,
    parameter int AddrWidth  = 16,
    parameter int SyncStages = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fmc_ne,
    input  logic                 fmc_noe,
    input  logic                 fmc_nwe,
    input  logic [AddrWidth-1:0] fmc_addr,
    output logic                 fmc_nwait,
    input  logic [DataWidth-1:0] pad_rdata,
    output logic [DataWidth-1:0] pad_wdata,
    output logic                 tristate_out,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic                 req_write,
    output logic [AddrWidth-1:0] req_addr,
    output logic [DataWidth-1:0] req_wdata,
    input  logic                 rsp_valid,
    input  logic [DataWidth-1:0] rsp_rdata
);
    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DRIVE, DONE} state_t;
    state_t state, state_nx;
    logic [SyncStages-1:0] ne_sync, noe_sync, nwe_sync;
    logic ne_s, noe_s, nwe_s, noe_d, nwe_d, noe_fall, nwe_fall, accept, rsp_got;
    assign ne_s     = ne_sync[SyncStages-1];
    assign noe_s    = noe_sync[SyncStages-1];
    assign nwe_s    = nwe_sync[SyncStages-1];
    assign noe_fall = !noe_s && noe_d;
    assign nwe_fall = !nwe_s && nwe_d;
    assign accept   = req_valid && req_ready;
    // raw-pin terms release the pads asynchronously for bus turnaround
    assign tristate_out = (state != RD_DRIVE) | fmc_noe | fmc_ne;
    // strobe synchronisers; reset to inactive so release never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ne_sync  <= '1;
            noe_sync <= '1;
            nwe_sync <= '1;
            noe_d    <= 1'b1;
            nwe_d    <= 1'b1;
        end else begin
            ne_sync  <= {ne_sync[SyncStages-2:0], fmc_ne};
            noe_sync <= {noe_sync[SyncStages-2:0], fmc_noe};
            nwe_sync <= {nwe_sync[SyncStages-2:0], fmc_nwe};
            noe_d    <= noe_s;
            nwe_d    <= nwe_s;
        end
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // next state; write edge takes priority over a coincident read edge
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = (!ne_s && nwe_fall) ? WR_REQ : (!ne_s && noe_fall) ? RD_REQ : IDLE;
            WR_REQ:   state_nx = accept ? DONE : WR_REQ;
            RD_REQ:   state_nx = accept ? RD_WAIT : RD_REQ;
            RD_WAIT:  state_nx = !rsp_got ? RD_WAIT : (!ne_s && !noe_s) ? RD_DRIVE : DONE;
            RD_DRIVE: state_nx = (noe_s || ne_s) ? DONE : RD_DRIVE;
            DONE:     state_nx = (noe_s && nwe_s) ? IDLE : DONE;
            default:  state_nx = IDLE;
        endcase
    end
    // request capture, response staging and wait generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            pad_wdata <= '0;
            rsp_got   <= 1'b0;
            fmc_nwait <= 1'b1;
        end else begin
            req_valid <= state_nx inside {WR_REQ, RD_REQ};
            if (state == IDLE && state_nx != IDLE) begin
                req_addr  <= fmc_addr;
                req_write <= state_nx == WR_REQ;
                if (state_nx == WR_REQ) req_wdata <= pad_rdata;
            end
            if (state == RD_WAIT && rsp_valid) pad_wdata <= rsp_rdata;
            rsp_got   <= state == RD_WAIT && state_nx == RD_WAIT && (rsp_got || rsp_valid);
            fmc_nwait <= !(state_nx inside {RD_REQ, RD_WAIT, RD_DRIVE}) || state == RD_DRIVE;
        end
    end
endmodule

// File: doc/fmc_slave_ctrl.md
Name: fmc_slave_ctrl

Overview:
- Fabric-side protocol engine for the STM32 FMC asynchronous SRAM-mode interface (NOR/PSRAM, non-multiplexed, 16-bit).
- Synchronises the FMC strobes, captures address and write data, and issues single-beat read/write requests onto an internal valid/ready register bus.
- Returns read data and drives the `in`/`tristate_out` inputs of the fmc_data_bus pad stage, which sits directly downstream.

Parameters:
- DataWidth, 16, width of the FMC data bus and of the register-bus data.
- AddrWidth, 16, number of FMC address pins sampled.
- SyncStages, 2, flop stages on `fmc_ne`, `fmc_noe` and `fmc_nwe`; must be ≥2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- fmc_ne  input  1  FMC chip select, active low, raw pin.
- fmc_noe  input  1  FMC output enable, active low, raw pin.
- fmc_nwe  input  1  FMC write enable, active low, raw pin.
- fmc_addr  input  AddrWidth  FMC address, raw pins.
- fmc_nwait  output  1  FMC wait, active low.
- pad_rdata  input  DataWidth  pad-to-fabric data; connects to fmc_data_bus `out`.
- pad_wdata  output  DataWidth  fabric-to-pad data; connects to fmc_data_bus `in`.
- tristate_out  output  1  1 = pads high-Z, 0 = drive; connects to fmc_data_bus `tristate_out`.
- req_valid  output  1  register-bus request valid.
- req_ready  input  1  register-bus request accepted.
- req_write  output  1  1 = write, 0 = read.
- req_addr  output  AddrWidth  request address.
- req_wdata  output  DataWidth  write data.
- rsp_valid  input  1  read response valid, single-cycle pulse.
- rsp_rdata  input  DataWidth  read response data.

Behaviour:
- Reset (async, immediate):
  - sync flops = 1 (inactive), so no spurious edge on reset release.
  - state = IDLE.
  - req_valid = 0, req_write = 0, req_addr = 0, req_wdata = 0, pad_wdata = 0.
  - tristate_out = 1, fmc_nwait = 1.
- Reset mid-transaction: any in-flight request is dropped and the pads release the same instant.
- Synchronisation:
  - ne_s, noe_s, nwe_s are the last sync stage.
  - A falling edge is the last stage = 0 while the previous registered value = 1.
  - Edges are acted on only in IDLE.
- IDLE:
  - ne_s = 0 and nwe_s falling → capture fmc_addr into req_addr and pad_rdata into req_wdata; set req_write = 1, req_valid = 1; go to WR_REQ.
  - Else ne_s = 0 and noe_s falling → capture req_addr; set req_write = 0, req_valid = 1; fmc_nwait = 0; go to RD_REQ.
  - Simultaneous NWE and NOE edges: write wins; the read edge is discarded.
- WR_REQ: hold all req_* stable until req_valid & req_ready; then req_valid = 0 (next cycle) and go to DONE. A rising ne_s never cancels an issued request.
- RD_REQ: same handshake; on acceptance go to RD_WAIT. fmc_nwait stays 0.
- RD_WAIT:
  - On rsp_valid: pad_wdata = rsp_rdata (registered).
  - If ne_s = 0 and noe_s = 0: go to RD_DRIVE.
  - Else (host aborted): go to DONE without driving.
  - rsp_valid seen in any other state is ignored.
- RD_DRIVE: fmc_nwait = 1 from the cycle after entry. Stay until noe_s = 1 or ne_s = 1, then go to DONE.
- DONE: go to IDLE when noe_s = 1 and nwe_s = 1. This blocks re-triggering within a single strobe.
- tristate_out:
  - Formula: tristate_out = ~(state == RD_DRIVE) | fmc_noe | fmc_ne.
  - The raw-pin terms are deliberate: they give asynchronous release for bus turnaround.
  - Outside RD_DRIVE the pads are never driven.
- fmc_nwait: 0 from RD_REQ entry until one cycle after RD_DRIVE entry; 1 otherwise (registered).
- Host timing requirements:
  - FMC DATAST ≥ SyncStages + 2 clk periods.
  - ADDSET ≥ 1 clk period.
  - NWAIT enabled for reads.
  - Address and write data must be stable while the strobe is low.
- Latency:
  - Write: strobe low → req_valid = SyncStages + 1 clk.
  - Read: rsp_valid → pad drive enabled = 2 clk (register into pad_wdata, then RD_DRIVE entry).

Test Plan:
- Write, req_ready tied 1: NE=0, addr=0x0012, data=0xBEEF, NWE low for 8 clk → exactly one req_valid pulse with write=1, addr=0x0012, wdata=0xBEEF; tristate_out stays 1 throughout.
- Read, response 3 clk after acceptance: NOE low at addr=0x0040, rsp_rdata=0x1234 → fmc_nwait=0 until data is driven; pad_wdata=0x1234 with tristate_out=0 while NOE low; tristate_out=1 in the same cycle NOE rises (combinational).
- Backpressure: req_ready held 0 for 10 clk during a write, with NWE released meanwhile → req_* stable for all 10 clk; single acceptance; returns to IDLE.
- Host abort: NE and NOE deasserted before rsp_valid → no drive ever (tristate_out=1); state returns to IDLE after rsp_valid; the next write is accepted normally.
- Simultaneous NOE/NWE fall, addr=0x0007 → one write request only, no read request.
- Reset asserted in RD_DRIVE → tristate_out=1, fmc_nwait=1, req_valid=0 immediately; with all strobes high at reset release, no request is generated.
